// File: rtl/reg_fp_subtractor.sv
// Multi-cycle magnitude subtractor for IEEE-754 single-layout operands.
// Input signs are ignored; the result sign says which magnitude was larger.
// Flow: IDLE -> ALIGN -> SUB -> (NORM x N) -> DONE. There is no rounding,
// and any result that underflows is flushed to zero.
module reg_fp_subtractor (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SUB   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] op_a, op_b;
  logic        res_sign;
  logic [7:0]  res_exp;
  logic [23:0] mant_l, mant_s, m;

  // Alignment datapath, driven from the captured operands.
  logic [30:0] mag_a, mag_b;
  logic        a_big;
  logic [7:0]  exp_l, exp_s, exp_gap;
  logic [23:0] man_l, man_s, man_s_shr;

  // Pick the larger magnitude and right-align the smaller mantissa to it.
  always_comb begin
    mag_a     = op_a[30:0];
    mag_b     = op_b[30:0];
    a_big     = (mag_a >= mag_b);
    exp_l     = a_big ? mag_a[30:23] : mag_b[30:23];
    exp_s     = a_big ? mag_b[30:23] : mag_a[30:23];
    man_l     = a_big ? {1'b1, mag_a[22:0]} : {1'b1, mag_b[22:0]};
    man_s     = a_big ? {1'b1, mag_b[22:0]} : {1'b1, mag_a[22:0]};
    exp_gap   = exp_l - exp_s;
    // A gap of 24 or more moves every bit of S out of range.
    man_s_shr = (exp_gap >= 8'd24) ? 24'd0 : (man_s >> exp_gap);
  end

  // Control FSM and datapath registers. Every output is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      res_sign <= 1'b0;
      res_exp  <= 8'd0;
      mant_l   <= 24'd0;
      mant_s   <= 24'd0;
      m        <= 24'd0;
      diff     <= 32'd0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          res_sign <= (mag_b > mag_a);
          res_exp  <= exp_l;
          mant_l   <= man_l;
          mant_s   <= man_s_shr;
          state    <= SUB;
        end
        SUB: begin
          // L is never smaller than the aligned S, so this cannot go negative.
          m <= mant_l - mant_s;
          if (mant_l == mant_s) begin
            diff  <= 32'd0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (m[23]) begin
            diff  <= {res_sign, res_exp, m[22:0]};
            done  <= 1'b1;
            state <= DONE;
          end else if (res_exp != 8'd0) begin
            // Normalise one bit per cycle.
            m       <= {m[22:0], 1'b0};
            res_exp <= res_exp - 8'd1;
          end else begin
            // The exponent is exhausted before the leading one is found: flush.
            diff  <= 32'd0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_fp_subtractor.sv
// Bench for reg_fp_subtractor: a table of directed vectors, hand sequences for
// the start-while-busy and reset-abort cases, and random operands checked
// against an arithmetic reference model.
// Cycle k is the interval after the k-th rising edge that follows the edge
// that samples start, so the start-sampling edge itself is edge 0.
module tb_reg_fp_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] diff;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] last_diff;
  bit          last_valid = 0;

  reg_fp_subtractor dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_diff;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model built from the arithmetic rules: compare magnitudes,
  // align, subtract, then find the leading one. Underflow flushes to zero.
  task automatic model(input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] rd, output int lat);
    int unsigned ma, mb, lg, sm, el, es, ml, ms, sh, mm, p, n;
    bit sgn;
    ma  = ia[30:0];
    mb  = ib[30:0];
    sgn = (mb > ma);
    lg  = sgn ? mb : ma;
    sm  = sgn ? ma : mb;
    el  = lg >> 23;
    es  = sm >> 23;
    ml  = (lg & 32'h7F_FFFF) | 32'h80_0000;
    ms  = (sm & 32'h7F_FFFF) | 32'h80_0000;
    sh  = el - es;
    ms  = (sh >= 24) ? 0 : (ms >> sh);
    mm  = ml - ms;
    if (mm == 0) begin
      rd  = 32'd0;
      lat = 2;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (mm[i]) p = i;
      n = 23 - p;
      if (n > el) begin
        rd  = 32'd0;
        lat = 3 + el;
      end else begin
        mm  = mm << n;
        rd  = {sgn, 8'(el - n), mm[22:0]};
        lat = 3 + n;
      end
    end
  endtask

  // Run one operation, starting in the current idle cycle.
  // When repulse is set, start is asserted again with junk operands while busy.
  task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp_diff, input int exp_lat, input bit repulse);
    int  cyc;
    bit  got, busy_ok;
    @(negedge clk);
    // An idle cycle right after DONE must accept the new request.
    chk({name, " idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, " idle_done"}, {31'd0, done}, 32'd0);
    if (last_valid) chk({name, " diff_hold"}, diff, last_diff);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1 start = 1'b0;
    cyc     = 0;
    got     = 0;
    busy_ok = 1;
    while (!got && cyc < 60) begin
      @(negedge clk);
      if (repulse && cyc == 1) begin
        start = 1'b1;
        a     = 32'h7F12_3456;
        b     = 32'h0000_0001;
      end
      if (repulse && cyc == 2) start = 1'b0;
      if (!busy) busy_ok = 0;
      if (done) got = 1;
      else cyc++;
    end
    start = 1'b0;
    chk({name, " done_seen"}, {31'd0, got}, 32'd1);
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " busy_while_active"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " diff"}, diff, exp_diff);
    last_diff  = exp_diff;
    last_valid = 1;
  endtask

  vec_t tbl[5];

  initial begin
    logic [31:0] rd, ra, rb;
    int          rl;
    bit          stray;

    tbl[0] = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3};
    tbl[1] = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 3};
    tbl[2] = '{32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 4};
    tbl[3] = '{32'h40A0_0000, 32'h40A0_0000, 32'h0000_0000, 2};
    tbl[4] = '{32'hC040_0000, 32'h3F80_0000, 32'h4000_0000, 3};

    reset = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_diff", diff, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp_diff, tbl[i].exp_lat, 0);
      model(tbl[i].a, tbl[i].b, rd, rl);
      chk($sformatf("tbl%0d model_agree", i), rd, tbl[i].exp_diff);
    end

    // An exponent gap of 24 drops S entirely; start is pulsed again while busy.
    run_op("gap24_repulse", 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 3, 1);
    // An exponent gap of 23 keeps only the hidden bit of S.
    run_op("gap23", 32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 4, 0);
    // Underflow: the leading one lies below what exponent 1 can absorb.
    model(32'h0080_0001, 32'h0080_0000, rd, rl);
    run_op("underflow", 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 4, 0);

    // Reset in the middle of normalisation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3FC0_0000;
    b     = 32'h3F80_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);  // cycle 2: in NORM
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", diff, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) stray = 1;
    end
    chk("abort_no_done", {31'd0, stray}, 32'd0);
    last_diff = 32'd0;
    run_op("after_reset", 32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 4, 0);

    // Random operands against the model.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = {1'($urandom), ra[30:23], 23'($urandom)};
        2: rb = {1'($urandom), 8'(ra[30:23] + $urandom_range(0, 6) - 3), 23'($urandom)};
        default: begin
          ra = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(0, 2)), ra[22:8], 8'($urandom)};
        end
      endcase
      model(ra, rb, rd, rl);
      run_op($sformatf("rnd%0d a=%h b=%h", i, ra, rb), ra, rb, rd, rl, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
